// File: rtl/msx_mouse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msx_mouse_pkg
// Description : Shared types and constants for the MSX joystick-port mouse
//               host: FSM state encoding, nibble index type, ps2_mouse flag
//               bit positions and default timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package msx_mouse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_NEXT   = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

    // Index of the nibble being read: 0 = X high, 1 = X low, 2 = Y high, 3 = Y low
    typedef logic [1:0] nib_idx_t;

    // Bit positions inside ps2_mouse[7:0]
    localparam int PS2_LBTN = 0;
    localparam int PS2_RBTN = 1;
    localparam int PS2_ONE  = 3;
    localparam int PS2_XSGN = 4;
    localparam int PS2_YSGN = 5;

    // 60 Hz poll and ~50 us settle at 21.48 MHz
    localparam int DEF_POLL_CYCLES   = 357955;
    localparam int DEF_SETTLE_CYCLES = 1074;

endpackage
`default_nettype wire

// File: rtl/msx_mouse_host_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Parameterized-width two-flop synchronizer for asynchronous
//               inputs.
// Ports       : clk  - destination clock
//               rst  - synchronous active-high reset (loads RST_VAL)
//               i_d  - asynchronous input bus
//               o_q  - synchronized output bus (2 cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/msx_mouse_host.sv
`default_nettype none
// ============================================================================
// Module      : msx_mouse_host
// Description : Initiator side of the MSX joystick-port mouse protocol.
//               Periodically toggles the port strobe, reads four nibbles
//               (X high, X low, Y high, Y low) and buttons, and converts them
//               into a MiSTer-style ps2_mouse packet.
// Ports       : clk_sys   - system clock
//               reset     - synchronous active-high reset
//               enable    - allows new polls to start
//               joy_in    - raw active-low port pins ([3:0] nibble,
//                           [4] left button, [5] right button), asynchronous
//               strobe    - port pin 8 drive
//               busy      - high while a poll sequence is in progress
//               ps2_mouse - {toggle, dy, dx, flags}
// Revision    : 1.0 - initial release
// ============================================================================
module msx_mouse_host
    import msx_mouse_pkg::*;
#(
    parameter int POLL_CYCLES   = DEF_POLL_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        enable,
    input  logic [5:0]  joy_in,
    output logic        strobe,
    output logic        busy,
    output logic [24:0] ps2_mouse
);

    localparam int c_poll_w   = (POLL_CYCLES   > 1) ? $clog2(POLL_CYCLES)   : 1;
    localparam int c_settle_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_poll_w-1:0]   c_poll_last   = c_poll_w'(POLL_CYCLES - 1);
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);

    logic [5:0]            w_joy;
    state_t                r_state;
    state_t                w_state_nx;
    logic [c_poll_w-1:0]   r_poll;
    logic [c_settle_w-1:0] r_settle;
    nib_idx_t              r_nib;
    logic [3:0]            r_raw [4];
    logic [1:0]            r_btn;       // {right, left}, active-high
    logic [1:0]            r_last_btn;
    logic                  r_strobe;
    logic [24:0]           r_ps2;

    logic       w_poll_tc, w_settle_tc;
    logic       w_start, w_sample, w_advance, w_finish, w_emit;
    logic [7:0] w_raw_x, w_raw_y;
    logic [8:0] w_neg_x;
    logic [7:0] w_dx, w_dy, w_flags;

    sync2 #(
        .WIDTH   (6),
        .RST_VAL (6'h3F)   // released, active-low pins idle high
    ) u_sync (
        .clk (clk_sys),
        .rst (reset),
        .i_d (joy_in),
        .o_q (w_joy)
    );

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        w_poll_tc   = (r_poll == c_poll_last);
        w_settle_tc = (r_settle == c_settle_last);
        w_start     = 1'b0;
        w_sample    = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_poll_tc && enable) begin
                    w_start    = 1'b1;
                    w_state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_settle_tc) begin
                    w_sample   = 1'b1;
                    w_state_nx = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_nib == 2'd3) begin
                    w_finish   = 1'b1;
                    w_state_nx = ST_EMIT;
                end else begin
                    w_advance  = 1'b1;
                    w_state_nx = ST_SETTLE;
                end
            end
            ST_EMIT: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // MSX deltas to ps2 convention. MSX positive is left/up, so X is
    // negated; -(-128) does not fit in 8 bits and saturates to +127.
    // Y keeps its sign but -128 is clamped to -127 for symmetry.
    // ------------------------------------------------------------------
    always_comb begin
        w_raw_x = {r_raw[0], r_raw[1]};
        w_raw_y = {r_raw[2], r_raw[3]};
        w_neg_x = 9'd0 - {w_raw_x[7], w_raw_x};
        if (!w_neg_x[8] && w_neg_x[7]) begin
            w_dx = 8'h7F;
        end else if (w_neg_x[8] && !w_neg_x[7]) begin
            w_dx = 8'h81;
        end else begin
            w_dx = w_neg_x[7:0];
        end
        w_dy = (w_raw_y == 8'h80) ? 8'h81 : w_raw_y;

        w_flags           = 8'h00;
        w_flags[PS2_LBTN] = r_btn[0];
        w_flags[PS2_RBTN] = r_btn[1];
        w_flags[PS2_ONE]  = 1'b1;
        w_flags[PS2_XSGN] = w_dx[7];
        w_flags[PS2_YSGN] = w_dy[7];

        w_emit = (r_state == ST_EMIT) &&
                 ((w_dx != 8'h00) || (w_dy != 8'h00) || (r_btn != r_last_btn));
    end

    // ------------------------------------------------------------------
    // State, counters and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_poll     <= '0;
            r_settle   <= '0;
            r_nib      <= '0;
            r_raw      <= '{default: 4'h0};
            r_btn      <= 2'b00;
            r_last_btn <= 2'b00;
            r_strobe   <= 1'b0;
            r_ps2      <= '0;
        end else begin
            // A sequence must always finish before the next poll slot
            assert (4 * SETTLE_CYCLES + 5 < POLL_CYCLES);

            r_state <= w_state_nx;

            // Free-running poll counter: wraps in every state so the poll
            // period stays fixed regardless of sequence activity
            r_poll <= w_poll_tc ? '0 : r_poll + 1'b1;

            if (w_start || w_advance) begin
                r_settle <= '0;
            end else if (r_state == ST_SETTLE) begin
                r_settle <= r_settle + 1'b1;
            end

            if (w_start) begin
                r_nib    <= '0;
                r_strobe <= ~r_strobe;
            end

            if (w_sample) begin
                r_raw[r_nib] <= ~w_joy[3:0];
            end

            if (w_advance) begin
                r_nib    <= r_nib + 2'd1;
                r_strobe <= ~r_strobe;
            end

            if (w_finish) begin
                r_btn <= ~w_joy[5:4];
            end

            if (w_emit) begin
                r_ps2      <= {~r_ps2[24], w_dy, w_dx, w_flags};
                r_last_btn <= r_btn;
            end
        end
    end

    assign strobe    = r_strobe;
    assign busy      = (r_state != ST_IDLE);
    assign ps2_mouse = r_ps2;

endmodule
`default_nettype wire

// File: tb/tb_msx_mouse_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_msx_mouse_host
// Description : Self-checking bench for msx_mouse_host. A behavioural MSX
//               mouse presents the nibble selected by the number of strobe
//               edges seen; a table of {mouse state, expected packet} records
//               is applied one poll per entry, followed by reset-mid-sequence
//               and enable-low sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msx_mouse_host;

    localparam int POLL   = 200;
    localparam int SETTLE = 10;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        enable;
    logic [5:0]  joy_in;
    logic        strobe;
    logic        busy;
    logic [24:0] ps2_mouse;

    int n_checks = 0;
    int n_errors = 0;

    msx_mouse_host #(
        .POLL_CYCLES   (POLL),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .enable    (enable),
        .joy_in    (joy_in),
        .strobe    (strobe),
        .busy      (busy),
        .ps2_mouse (ps2_mouse)
    );

    always #5 clk_sys = ~clk_sys;

    // ------------------------------------------------------------------
    // Mouse model
    // ------------------------------------------------------------------
    logic [7:0] m_x, m_y;
    logic       m_lb, m_rb;
    logic [1:0] m_sel = 2'd3;
    logic       m_prev = 1'b0;
    logic [3:0] m_nib;

    always @(negedge clk_sys) begin
        if (reset) begin
            m_sel  <= 2'd3;
            m_prev <= 1'b0;
        end else if (strobe !== m_prev) begin
            m_sel  <= m_sel + 2'd1;
            m_prev <= strobe;
        end
    end

    always_comb begin
        m_nib = 4'h0;
        case (m_sel)
            2'd0:    m_nib = m_x[7:4];
            2'd1:    m_nib = m_x[3:0];
            2'd2:    m_nib = m_y[7:4];
            default: m_nib = m_y[3:0];
        endcase
        joy_in = {~m_rb, ~m_lb, ~m_nib};
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_rise(input int budget, output int n, output logic found);
        logic prev;
        prev  = strobe;
        n     = 0;
        found = 1'b0;
        while (n < budget && !found) begin
            @(negedge clk_sys);
            n++;
            if (strobe === 1'b1 && prev === 1'b0) found = 1'b1;
            prev = strobe;
        end
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       lb;
        logic       rb;
        logic       upd;
        logic [7:0] dx;
        logic [7:0] dy;
        logic [7:0] fl;
    } vec_t;

    localparam int NV = 10;
    vec_t        vecs [NV];
    logic [24:0] exp_ps2;

    // Called on the negedge right after the strobe rise that starts a poll;
    // the packet must update exactly 4*SETTLE+5 cycles after that edge.
    task automatic finish_poll(input string tag, input logic upd,
                               input logic [7:0] dx, input logic [7:0] dy,
                               input logic [7:0] fl);
        check($sformatf("%s busy_at_start", tag), {31'd0, busy}, 32'd1);
        repeat (4 * SETTLE + 4) @(negedge clk_sys);
        check($sformatf("%s hold_before_emit", tag), {7'd0, ps2_mouse}, {7'd0, exp_ps2});
        check($sformatf("%s busy_in_emit", tag), {31'd0, busy}, 32'd1);
        @(negedge clk_sys);
        if (upd) exp_ps2 = {~exp_ps2[24], dy, dx, fl};
        check($sformatf("%s packet", tag), {7'd0, ps2_mouse}, {7'd0, exp_ps2});
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int   n;
        logic found;

        //          x      y      lb    rb    upd   dx     dy     flags
        vecs[0] = '{8'h05, 8'hFE, 1'b0, 1'b0, 1'b1, 8'hFB, 8'hFE, 8'h38};
        vecs[1] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h09};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h08};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h81, 8'h28};
        vecs[5] = '{8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 8'h0A};
        vecs[6] = '{8'h7F, 8'h7F, 1'b0, 1'b1, 1'b1, 8'h81, 8'h7F, 8'h1A};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[8] = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h0B};
        vecs[9] = '{8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'hEE, 8'h34, 8'h18};

        exp_ps2 = '0;
        reset   = 1'b1;
        enable  = 1'b1;
        m_x = 8'h00; m_y = 8'h00; m_lb = 1'b0; m_rb = 1'b0;

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("reset strobe", {31'd0, strobe}, 32'd0);
        check("reset busy",   {31'd0, busy},   32'd0);
        check("reset ps2",    {7'd0, ps2_mouse}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            m_x  = vecs[i].x;
            m_y  = vecs[i].y;
            m_lb = vecs[i].lb;
            m_rb = vecs[i].rb;
            wait_rise(2 * POLL, n, found);
            check($sformatf("v%0d poll_found", i), {31'd0, found}, 32'd1);
            // First poll lands POLL cycles after reset release; later ones keep
            // a POLL-cycle period (we resume 4*SETTLE+5 cycles after a start)
            check($sformatf("v%0d poll_gap", i), n,
                  (i == 0) ? POLL : POLL - (4 * SETTLE + 5));
            if (found)
                finish_poll($sformatf("v%0d", i), vecs[i].upd,
                            vecs[i].dx, vecs[i].dy, vecs[i].fl);
        end

        // Reset during the third nibble's settle window
        m_x = 8'h21; m_y = 8'h43; m_lb = 1'b0; m_rb = 1'b0;
        wait_rise(2 * POLL, n, found);
        check("midrst poll_found", {31'd0, found}, 32'd1);
        repeat (25) @(negedge clk_sys);
        check("midrst strobe_high_before", {31'd0, strobe}, 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        check("midrst strobe", {31'd0, strobe}, 32'd0);
        check("midrst busy",   {31'd0, busy},   32'd0);
        check("midrst ps2",    {7'd0, ps2_mouse}, 32'd0);
        exp_ps2 = '0;
        @(negedge clk_sys);
        reset = 1'b0;
        wait_rise(2 * POLL, n, found);
        check("after_rst poll_found", {31'd0, found}, 32'd1);
        check("after_rst poll_gap", n, POLL);
        if (found)
            finish_poll("after_rst", 1'b1, 8'hDF, 8'h43, 8'h18);

        // Enable low blocks new polls
        enable = 1'b0;
        wait_rise(2 * POLL + 20, n, found);
        check("disabled no_poll", {31'd0, found}, 32'd0);
        check("disabled busy",    {31'd0, busy},  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
